// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle fetch/memory stage: PC-source select,
// handshake FSM states and access-type tags.
package mc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10
    } mem_op_e;

    // True when at least two of the three memory strobes are active together.
    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Variable-latency memory handshake: accepts one strobe, holds the request
// until mem_ready, and produces stall, capture enables and the sticky error flag.
module mem_handshake_fsm
    import mc_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ir_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          iord,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out,
    input  logic [AW-1:0] write_data,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          stall,
    output logic          err,
    output logic          ir_load,
    output logic          mdr_load
);

    state_e        state_r;
    mem_op_e       op_r;
    mem_op_e       op_s;
    logic          any_strobe_s;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [AW-1:0] mem_wdata_r;
    logic          err_r;
    logic          stall_s;
    logic          ir_load_s;
    logic          mdr_load_s;
    logic          ready_s;

    assign any_strobe_s = ir_write | mem_read | mem_write;
    assign ready_s      = mem_ready & mem_req_r;

    // Strobe priority: fetch over load over store.
    always_comb begin
        op_s = OP_STORE;
        if (ir_write) begin
            op_s = OP_FETCH;
        end else if (mem_read) begin
            op_s = OP_LOAD;
        end else begin
            op_s = OP_STORE;
        end
    end

    // Stall is combinational so a fetch strobe blocks the PC in its own cycle.
    always_comb begin
        stall_s    = 1'b0;
        ir_load_s  = 1'b0;
        mdr_load_s = 1'b0;
        case (state_r)
            IDLE: stall_s = any_strobe_s;
            WAIT: begin
                stall_s    = 1'b1;
                ir_load_s  = ready_s & (op_r == OP_FETCH);
                mdr_load_s = ready_s & (op_r == OP_LOAD);
            end
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Handshake state, latched request fields and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= OP_FETCH;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {AW{1'b0}};
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_strobe_s) begin
                        state_r     <= WAIT;
                        op_r        <= op_s;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= (op_s == OP_STORE);
                        mem_addr_r  <= iord ? alu_out : pc;
                        mem_wdata_r <= write_data;
                        if (multi_strobe(ir_write, mem_read, mem_write)) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (ready_s) begin
                        state_r   <= DONE;
                        mem_req_r <= 1'b0;
                    end
                end
                DONE: state_r <= IDLE;
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign err       = err_r;
    assign stall     = stall_s;
    assign ir_load   = ir_load_s;
    assign mdr_load  = mdr_load_s;

endmodule

// File: rtl/pc_ir_mem_unit.sv
// Multicycle MIPS fetch/memory stage: PC, IR and MDR registers plus the
// next-PC mux, with the memory handshake delegated to mem_handshake_fsm.
module pc_ir_mem_unit
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          AW       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        zero,
    input  logic [1:0]  pc_src,
    input  logic        ir_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        iord,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        err
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] mdr_r;
    logic [31:0] pc_next_s;
    logic        pc_en_s;
    logic        ir_load_s;
    logic        mdr_load_s;

    mem_handshake_fsm #(.AW(32)) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .pc         (pc_r),
        .alu_out    (alu_out),
        .write_data (write_data),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .err        (err),
        .ir_load    (ir_load_s),
        .mdr_load   (mdr_load_s)
    );

    assign pc_en_s = (pc_write | (branch & zero)) & ~stall;

    // Next-PC select; the jump target keeps the upper PC nibble.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_src)
            PCSRC_ALU:    pc_next_s = alu_result;
            PCSRC_ALUOUT: pc_next_s = alu_out;
            PCSRC_JUMP:   pc_next_s = {pc_r[31:28], instr_r[25:0], 2'b00};
            PCSRC_HOLD:   pc_next_s = pc_r;
            default:      pc_next_s = pc_r;
        endcase
    end

    // Architectural PC, instruction and memory-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            mdr_r   <= 32'h0000_0000;
        end else begin
            if (pc_en_s) begin
                pc_r <= pc_next_s;
            end
            if (ir_load_s) begin
                instr_r <= mem_rdata;
            end
            if (mdr_load_s) begin
                mdr_r <= mem_rdata;
            end
        end
    end

    assign pc     = pc_r;
    assign instr  = instr_r;
    assign mdr    = mdr_r;
    assign opcode = instr_r[31:26];
    assign funct  = instr_r[5:0];

endmodule

// File: tb/tb_pc_ir_mem_unit.sv
// Directed bench for pc_ir_mem_unit: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_pc_ir_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, branch, zero, ir_write, mem_read, mem_write, iord, mem_ready;
    logic [1:0]  pc_src;
    logic [31:0] alu_result, alu_out, write_data, mem_rdata;
    logic        mem_req, mem_we, stall, err;
    logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
    logic [5:0]  opcode, funct;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_ir_mem_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .branch(branch), .zero(zero),
        .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .alu_result(alu_result), .alu_out(alu_out), .write_data(write_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc), .instr(instr),
        .opcode(opcode), .funct(funct), .mdr(mdr), .stall(stall), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; the caller then drives and checks.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; branch = 1'b0; zero = 1'b0; pc_src = 2'b00;
        ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; mem_ready = 1'b0;
        alu_result = 32'h0; alu_out = 32'h0; write_data = 32'h0; mem_rdata = 32'h0;
        cyc(); cyc(); #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_mdr", mdr, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        cyc(); rst_n = 1'b1;

        // Zero-wait fetch with PC+4
        cyc(); ir_write = 1'b1; pc_write = 1'b1; pc_src = 2'b00; alu_result = 32'h4;
        mem_ready = 1'b1; mem_rdata = 32'h8C01_0004; #1;
        check("f0_stall_c0", {31'h0, stall}, 32'h1);
        check("f0_req_c0", {31'h0, mem_req}, 32'h0);
        cyc(); #1;
        check("f0_req_c1", {31'h0, mem_req}, 32'h1);
        check("f0_addr_c1", mem_addr, 32'h0);
        check("f0_stall_c1", {31'h0, stall}, 32'h1);
        check("f0_pc_c1", pc, 32'h0);
        cyc(); #1;
        check("f0_stall_c2", {31'h0, stall}, 32'h0);
        check("f0_pc_c2", pc, 32'h0);
        cyc(); ir_write = 1'b0; pc_write = 1'b0; #1;
        check("f0_pc_c3", pc, 32'h4);
        check("f0_instr_c3", instr, 32'h8C01_0004);
        check("f0_opcode", {26'h0, opcode}, 32'h23);
        check("f0_funct", {26'h0, funct}, 32'h04);
        check("f0_req_c3", {31'h0, mem_req}, 32'h0);

        // Fetch with memory answering in the fifth request cycle
        cyc(); ir_write = 1'b1; pc_write = 1'b1; alu_result = 32'h8; mem_ready = 1'b0;
        mem_rdata = 32'h0000_0020;
        for (int i = 1; i <= 5; i++) begin
            cyc(); mem_ready = (i == 5); #1;
            check("f5_req", {31'h0, mem_req}, 32'h1);
            check("f5_addr", mem_addr, 32'h4);
            check("f5_stall", {31'h0, stall}, 32'h1);
            check("f5_pc", pc, 32'h4);
        end
        cyc(); #1;
        check("f5_done_stall", {31'h0, stall}, 32'h0);
        check("f5_done_pc", pc, 32'h4);
        check("f5_instr", instr, 32'h0000_0020);
        cyc(); ir_write = 1'b0; pc_write = 1'b0; mem_ready = 1'b1; #1;
        check("f5_pc_after", pc, 32'h8);

        // Load through alu_out
        cyc(); iord = 1'b1; alu_out = 32'h100; mem_read = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        check("ld_stall_c0", {31'h0, stall}, 32'h1);
        cyc(); #1;
        check("ld_addr", mem_addr, 32'h100);
        check("ld_we", {31'h0, mem_we}, 32'h0);
        check("ld_req", {31'h0, mem_req}, 32'h1);
        cyc(); mem_read = 1'b0; #1;
        check("ld_mdr", mdr, 32'hDEAD_BEEF);
        check("ld_instr", instr, 32'h0000_0020);
        check("ld_pc", pc, 32'h8);

        // Store; read data must not land anywhere
        cyc(); alu_out = 32'h200; write_data = 32'h1234_5678; mem_write = 1'b1;
        mem_rdata = 32'hCAFE_F00D; #1;
        check("st_stall_c0", {31'h0, stall}, 32'h1);
        cyc(); #1;
        check("st_we", {31'h0, mem_we}, 32'h1);
        check("st_wdata", mem_wdata, 32'h1234_5678);
        check("st_addr", mem_addr, 32'h200);
        cyc(); mem_write = 1'b0; iord = 1'b0; #1;
        check("st_mdr", mdr, 32'hDEAD_BEEF);
        check("st_instr", instr, 32'h0000_0020);

        // Branch not taken, then taken
        cyc(); branch = 1'b1; pc_src = 2'b01; alu_out = 32'h40; zero = 1'b0; #1;
        check("br_stall", {31'h0, stall}, 32'h0);
        cyc(); zero = 1'b1; #1;
        check("br_nt_pc", pc, 32'h8);
        cyc(); branch = 1'b0; zero = 1'b0; #1;
        check("br_t_pc", pc, 32'h40);

        // Fetch a jump instruction without moving PC, then jump
        cyc(); ir_write = 1'b1; mem_rdata = 32'h0800_0010;
        cyc(); #1;
        check("j_fetch_addr", mem_addr, 32'h40);
        cyc(); ir_write = 1'b0;
        cyc(); pc_write = 1'b1; pc_src = 2'b00; alu_result = 32'h1000_0000; #1;
        check("j_instr", instr, 32'h0800_0010);
        cyc(); pc_src = 2'b10; #1;
        check("j_pc_base", pc, 32'h1000_0000);
        cyc(); pc_src = 2'b11; #1;
        check("j_pc_target", pc, 32'h1000_0040);
        cyc(); pc_write = 1'b0; #1;
        check("hold_pc", pc, 32'h1000_0040);

        // Reset in the middle of an outstanding fetch
        cyc(); ir_write = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        cyc(); #1;
        check("ra_req_before", {31'h0, mem_req}, 32'h1);
        #1; rst_n = 1'b0; ir_write = 1'b0; #1;
        check("ra_req", {31'h0, mem_req}, 32'h0);
        check("ra_pc", pc, 32'h0);
        check("ra_instr", instr, 32'h0);
        check("ra_stall", {31'h0, stall}, 32'h0);
        cyc(); rst_n = 1'b1; mem_ready = 1'b1;

        // Fetch and load together: fetch wins, err becomes sticky
        cyc(); ir_write = 1'b1; mem_read = 1'b1; mem_rdata = 32'h2108_0001; #1;
        check("er_err_c0", {31'h0, err}, 32'h0);
        cyc(); #1;
        check("er_err_c1", {31'h0, err}, 32'h1);
        check("er_we", {31'h0, mem_we}, 32'h0);
        check("er_addr", mem_addr, 32'h0);
        cyc(); ir_write = 1'b0; mem_read = 1'b0; #1;
        check("er_instr", instr, 32'h2108_0001);
        check("er_mdr", mdr, 32'h0);
        cyc(); cyc(); #1;
        check("er_sticky", {31'h0, err}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
